interconn_recv_buffer: RTL
==========================

// Module: interconn_recv_buffer
// PURPOSE
//  Receive-side stage directly downstream of interconn_priority, one instance per MVU.
//  Captures {recv_from, recv_addr, recv_word} whenever recv_en is high.
//  Queues the captured words in a small FIFO and writes them into the MVU data memory
//  whenever the MVU's own write port is idle.
//  Reports overflow/drop and malformed-source errors; the interconnect has no backpressure.
// PARAMETERS
//  N      8   number of MVUs (width of recv_from one-hot)
//  W      64  data word width
//  BADDR  15  memory address width
//  DEPTH  4   FIFO entries (power of 2, >=2)
// PORTS
//  clk         in   1            clock, all state on rising edge
//  clr_n       in   1            asynchronous reset, active-low
//  recv_from   in   N            one-hot source MVU, from interconnect
//  recv_en     in   1            word valid this cycle (single-cycle pulse per word)
//  recv_addr   in   BADDR        destination memory address
//  recv_word   in   W            data word
//  mem_busy    in   1            MVU owns the memory write port this cycle
//  mem_we      out  1            write strobe to memory
//  mem_addr    out  BADDR        write address (FIFO head)
//  mem_word    out  W            write data (FIFO head)
//  mem_src     out  $clog2(N)    binary-encoded source MVU of head entry
//  level       out  $clog2(DEPTH)+1  current FIFO occupancy
//  ovf         out  1            sticky: a word was dropped
//  src_err     out  1            sticky: recv_en with recv_from not one-hot
//  drop_cnt    out  8            dropped-word count, saturates at 255
//  err_clr     in   1            synchronous clear of ovf, src_err, drop_cnt
// BEHAVIOUR
//  Reset (clr_n low, async):
//   - FIFO flushed, rd/wr pointers = 0, level = 0.
//   - ovf = src_err = 0, drop_cnt = 0.
//   - mem_we = 0; mem_addr/mem_word/mem_src = 0.
//   - Reset mid-operation discards all queued words; no write is issued after reset.
//  FIFO:
//   - Circular buffer; pointers wrap modulo DEPTH.
//   - Full/empty are derived from level (0..DEPTH).
//   - Push: on an edge where recv_en=1 and (level<DEPTH or pop occurs on that same edge).
//   - Pop:  on an edge where mem_we=1.
//   - Simultaneous push+pop at full: both occur, level unchanged.
//   - Simultaneous push+pop at empty: impossible, because mem_we requires level>0.
//  Output:
//   - mem_we = (level!=0) & ~mem_busy, combinational from registered state plus mem_busy.
//   - mem_addr/mem_word/mem_src show the head entry, registered; they are 0 when empty.
//  Latency:
//   - recv_en in cycle t into an empty FIFO gives mem_we in cycle t+1 if mem_busy=0 then.
//   - No same-cycle bypass.
//  mem_busy:
//   - While high, mem_we=0 and the head is held.
//   - Writes drain in FIFO order, one per idle cycle.
//  Source encode:
//   - mem_src is the index of the set bit of recv_from, captured at push.
//   - If recv_from is not one-hot (zero or multi-bit): the word is still pushed with
//     mem_src = lowest set bit index (0 if none), and src_err is set.
//  Drop:
//   - recv_en while full with no pop: word discarded, ovf <= 1,
//     drop_cnt <= min(drop_cnt+1, 255).
//  err_clr:
//   - Clears ovf/src_err/drop_cnt.
//   - If a drop or src error occurs on the same edge, the set wins:
//     flag = 1, drop_cnt = 1 for a drop.
//  Back-to-back recv_en every cycle with mem_busy=0:
//   - Steady state level = 1, no drops.
// TESTING
//  1. Reset, then recv_en 1 cycle {from=8'b0000_0100, addr=7, word=64'hdeadbeefdeadbeef}
//     -> next cycle mem_we=1, mem_addr=7, mem_word=deadbeef..., mem_src=2; level returns 0.
//  2. mem_busy=1 held; send 4 words addr 0..3 -> level=4, mem_we=0.
//     Drop mem_busy -> 4 writes on consecutive cycles, addr 0,1,2,3, in order.
//  3. mem_busy=1; send 6 words -> level=4, ovf=1, drop_cnt=2, words 5-6 never written.
//     Pulse err_clr -> ovf=0, drop_cnt=0.
//  4. Fill to 4 with mem_busy=1, then release mem_busy on the same cycle a 5th recv_en
//     arrives -> no drop, level stays 4, 5th word written last.
//  5. recv_en with from=8'b0001_0001 -> src_err=1, mem_src=0, word still written.
//     Also run from=0.
//  6. Assert clr_n low mid-drain with 3 queued -> mem_we=0 immediately, level=0,
//     no further writes after release.

Source files
------------

// File: rtl/interconn_recv_buffer.sv
// ---------------------------------------------------------------------------
// interconn_recv_buffer
//
// Receive-side buffer placed directly after interconn_priority, one per MVU.
// Every cycle that recv_en is high the tuple {recv_from, recv_addr, recv_word}
// is captured into a small circular FIFO. The head entry is written into the
// MVU data memory whenever the MVU is not using its own write port
// (mem_busy low). The interconnect cannot be stalled, so a word that arrives
// while the FIFO is full and nothing drains on that edge is dropped. Drops
// and malformed source vectors are reported through sticky flags.
//
// Ports
//   clk        in   clock, all state on the rising edge
//   clr_n      in   asynchronous reset, active-low
//   recv_from  in   one-hot source MVU
//   recv_en    in   word valid this cycle
//   recv_addr  in   destination memory address
//   recv_word  in   data word
//   mem_busy   in   MVU owns the memory write port this cycle
//   mem_we     out  write strobe to memory
//   mem_addr   out  write address of the head entry (0 when empty)
//   mem_word   out  write data of the head entry (0 when empty)
//   mem_src    out  binary source index of the head entry (0 when empty)
//   level      out  FIFO occupancy, 0..DEPTH
//   ovf        out  sticky: a word was dropped
//   src_err    out  sticky: recv_en seen with recv_from not one-hot
//   drop_cnt   out  dropped-word count, saturating at 255
//   err_clr    in   synchronous clear of ovf, src_err, drop_cnt
// ---------------------------------------------------------------------------
module interconn_recv_buffer #(
    parameter int N     = 8,
    parameter int W     = 64,
    parameter int BADDR = 15,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic [N-1:0]               recv_from,
    input  logic                       recv_en,
    input  logic [BADDR-1:0]           recv_addr,
    input  logic [W-1:0]               recv_word,
    input  logic                       mem_busy,
    output logic                       mem_we,
    output logic [BADDR-1:0]           mem_addr,
    output logic [W-1:0]               mem_word,
    output logic [$clog2(N)-1:0]       mem_src,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ovf,
    output logic                       src_err,
    output logic [7:0]                 drop_cnt,
    input  logic                       err_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int SW = $clog2(N);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    // Lowest set bit index; 0 when no bit is set.
    function automatic logic [SW-1:0] low_index(input logic [N-1:0] v);
        logic [SW-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) r = SW'(i);
        end
        return r;
    endfunction

    function automatic logic is_onehot(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    // Entry storage: data only, never reset.
    logic [BADDR-1:0] addr_q [DEPTH];
    logic [W-1:0]     word_q [DEPTH];
    logic [SW-1:0]    src_q  [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic          push;
    logic          pop;
    logic          drop;
    logic          bad_src;
    logic [SW-1:0] in_src;
    logic [PW-1:0] rd_nxt;
    logic [LW-1:0] lvl_nxt;

    logic [BADDR-1:0] head_addr_nxt;
    logic [W-1:0]     head_word_nxt;
    logic [SW-1:0]    head_src_nxt;

    assign mem_we  = (level != '0) && !mem_busy;
    assign pop     = mem_we;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push    = recv_en && ((level != FULL_LVL) || pop);
    assign drop    = recv_en && !push;
    assign bad_src = recv_en && !is_onehot(recv_from);
    assign in_src  = low_index(recv_from);

    always_comb begin
        rd_nxt  = pop ? rd_ptr + PW'(1) : rd_ptr;
        lvl_nxt = level;
        if (push && !pop) lvl_nxt = level + LW'(1);
        else if (!push && pop) lvl_nxt = level - LW'(1);

        // The head register is loaded with what will sit at rd_nxt after this
        // edge. If that slot is the one being written now, take the incoming
        // word directly since storage is not updated yet.
        head_addr_nxt = '0;
        head_word_nxt = '0;
        head_src_nxt  = '0;
        if (lvl_nxt != '0) begin
            if (push && (rd_nxt == wr_ptr)) begin
                head_addr_nxt = recv_addr;
                head_word_nxt = recv_word;
                head_src_nxt  = in_src;
            end else begin
                head_addr_nxt = addr_q[rd_nxt];
                head_word_nxt = word_q[rd_nxt];
                head_src_nxt  = src_q[rd_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= recv_addr;
            word_q[wr_ptr] <= recv_word;
            src_q[wr_ptr]  <= in_src;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            mem_addr <= '0;
            mem_word <= '0;
            mem_src  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            rd_ptr   <= rd_nxt;
            level    <= lvl_nxt;
            mem_addr <= head_addr_nxt;
            mem_word <= head_word_nxt;
            mem_src  <= head_src_nxt;
        end
    end

    // Error flags: a new event on the same edge as err_clr survives the clear.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ovf      <= 1'b0;
            src_err  <= 1'b0;
            drop_cnt <= 8'd0;
        end else if (err_clr) begin
            ovf      <= drop;
            src_err  <= bad_src;
            drop_cnt <= drop ? 8'd1 : 8'd0;
        end else begin
            if (drop) begin
                ovf      <= 1'b1;
                drop_cnt <= sat_inc(drop_cnt);
            end
            if (bad_src) src_err <= 1'b1;
        end
    end

endmodule
